aes_req_arbiter: RTL and testbench
==================================

Name: aes_req_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single AES128 core between NUM_REQ requesters, for example the UART command path and a future streaming/self-test source. It captures a winner's text, key and direction, then pulses the core's start. It waits for the core's done, latches the result and returns it to the winner with a one-cycle done pulse. It sits between the requesters and the AES core instance in the top level.

Parameters:
NUM_REQ, 2, number of requesters (legal 2..8)
IDX_W, 1, requester index width = clog2(NUM_REQ), minimum 1
TIMEOUT_CYC, 64, AES wait limit in cycles (used only with AES_TIMEOUT_EN)

Ports:
i_Clk  in  1  clock, all logic on rising edge
i_Rst  in  1  asynchronous active-low reset
i_Req  in  NUM_REQ  per-requester request level
i_Dec  in  NUM_REQ  per-requester direction, 1 = decrypt
i_Text  in  NUM_REQ*128  flattened input blocks, requester n at [n*128+:128]
i_Key  in  NUM_REQ*128  flattened keys, same packing
o_Ack  out  NUM_REQ  one-hot one-cycle pulse: request captured
o_Done  out  NUM_REQ  one-hot one-cycle pulse: result valid on o_Data
o_Data  out  128  result of last completed operation
o_Err  out  1  pulses with o_Done on timeout (0 without AES_TIMEOUT_EN)
o_Busy  out  1  high in every state except IDLE
o_AesStart  out  1  one-cycle start to AES core
o_AesDec  out  1  direction to AES core
o_AesText  out  128  block to AES core
o_AesKey  out  128  key to AES core
i_AesData  in  128  AES core result
i_AesDone  in  1  AES core done pulse

Behaviour:
- Reset: state IDLE, all outputs 0, internal text/key/result registers 0, grant index 0, RR pointer c_Last = NUM_REQ-1 so requester 0 has first priority.
- States: IDLE, START, WAIT, DONE.
- IDLE: i_Req sampled only here. If any bit is set, the winner is the first set bit searching upward from c_Last+1 (mod NUM_REQ).
  - Latch the winner's i_Text, i_Key, i_Dec and index, then go to START.
  - If no bit is set, stay in IDLE.
- START (1 cycle): o_Ack[idx]=1 and o_AesStart=1 in the same cycle, then go to WAIT.
- WAIT: on i_AesDone, latch i_AesData into the result register and go to DONE.
- DONE (1 cycle): o_Done[idx]=1, o_Data = new result, c_Last <= idx, then go to IDLE.
- Latency: i_Req sampled in IDLE at cycle T gives ack/start at T+1. i_AesDone at cycle D gives o_Done at D+1 and IDLE at D+2. The earliest next grant is sampled at D+2.
- o_AesText, o_AesKey and o_AesDec are driven from the latched registers and held stable from START until the next capture.
- o_Data holds its value until the next DONE.
- A requester must deassert i_Req in the cycle after o_Ack. A level still high when the arbiter returns to IDLE is a new request.
- i_AesDone in IDLE, START or DONE is ignored.
- Requests arriving while busy wait; nothing is queued or dropped.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,..,NUM_REQ-1,0.
- Reset mid-operation: immediate return to the reset state. The aborted requester gets no o_Done. The AES core is reset by the same i_Rst.

Optional Feature:
AES_TIMEOUT_EN
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC without i_AesDone, go to DONE with o_Err=1 and the result register forced to 0. o_Done pulses normally.
  - i_AesDone in the same cycle the limit is reached wins: normal completion, o_Err=0.
- Undefined: no counter is built, o_Err is tied to 0, and WAIT lasts indefinitely.

Decomposition:
- Package aes_arb_pkg holds:
  - state encoding (2-bit IDLE=0, START=1, WAIT=2, DONE=3)
  - AES_BLK_W=128
  - TIMEOUT counter width constant
- One sub-module, rr_picker: combinational. Inputs: request vector and c_Last. Outputs: valid and winner index. It is reusable for other shared resources.

Test Plan:
- Single request: i_Req=01, Text=00112233445566778899aabbccddeeff, Key=000102..0f, Dec=0. Expect o_Ack[0] and o_AesStart at T+1. AES done gives o_Done[0] with o_Data=69c4e0d86a7b0430d8cdb78070b4c55a.
- Simultaneous requests: i_Req=11 from reset. Expect grant order 0 then 1. Each gets its own result and Ack/Done on its own bit only.
- Sustained contention, NUM_REQ=4, i_Req=1111 held: expect grant sequence 0,1,2,3,0 and no requester granted twice in a row.
- Spurious done: i_AesDone pulsed in IDLE and in START. Expect no state change and no o_Done.
- Reset asserted in WAIT: all outputs 0 immediately. After release, i_Req=10 is granted to requester 1 with correct data.
- With AES_TIMEOUT_EN, TIMEOUT_CYC=8 and no i_AesDone: expect o_Done plus o_Err 8 cycles after entering WAIT, with o_Data=0.

Source files
------------

// File: rtl/aes_arb_pkg.sv
// Shared state encoding and widths for the AES request arbiter and its helpers.
package aes_arb_pkg;

    localparam int AES_BLK_W = 128;
    localparam int TMO_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/aes_req_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request searching upward from last+1.
// Independent of the AES datapath so it can front any shared resource.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // Rank every set request by its distance past 'last'; the smallest rank wins.
    always_comb begin
        int best_off;
        int off;
        valid    = 1'b0;
        idx      = '0;
        best_off = NUM_REQ;
        off      = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            off = (j - int'(last) - 1 + 2 * NUM_REQ) % NUM_REQ;
            if (req[j] && (off < best_off)) begin
                best_off = off;
                idx      = IDX_W'(j);
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES128 core between NUM_REQ requesters: round-robin grant, start, wait, return.
// Optional wait-timeout is built only when AES_TIMEOUT_EN is defined.
module aes_req_arbiter
    import aes_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int IDX_W       = 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst,
    input  logic [NUM_REQ-1:0]           i_Req,
    input  logic [NUM_REQ-1:0]           i_Dec,
    input  logic [NUM_REQ*AES_BLK_W-1:0] i_Text,
    input  logic [NUM_REQ*AES_BLK_W-1:0] i_Key,
    output logic [NUM_REQ-1:0]           o_Ack,
    output logic [NUM_REQ-1:0]           o_Done,
    output logic [AES_BLK_W-1:0]         o_Data,
    output logic                         o_Err,
    output logic                         o_Busy,
    output logic                         o_AesStart,
    output logic                         o_AesDec,
    output logic [AES_BLK_W-1:0]         o_AesText,
    output logic [AES_BLK_W-1:0]         o_AesKey,
    input  logic [AES_BLK_W-1:0]         i_AesData,
    input  logic                         i_AesDone
);

    arb_state_t state;
    arb_state_t next_state;

    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic [AES_BLK_W-1:0] sel_text;
    logic [AES_BLK_W-1:0] sel_key;
    logic                 sel_dec;

    logic [AES_BLK_W-1:0] text_q;
    logic [AES_BLK_W-1:0] key_q;
    logic                 dec_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     c_Last;
    logic [AES_BLK_W-1:0] result_q;
    logic [NUM_REQ-1:0]   grant_vec;
    logic                 tmo_hit;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req   (i_Req),
        .last  (c_Last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Select the candidate winner's operands from the flattened buses.
    always_comb begin
        sel_text = '0;
        sel_key  = '0;
        sel_dec  = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pick_idx == IDX_W'(j)) begin
                sel_text = i_Text[j*AES_BLK_W +: AES_BLK_W];
                sel_key  = i_Key[j*AES_BLK_W +: AES_BLK_W];
                sel_dec  = i_Dec[j];
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        o_Ack      = '0;
        o_Done     = '0;
        o_AesStart = 1'b0;
        o_Busy     = (state != IDLE);
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    next_state = START;
                end
            end
            START: begin
                o_Ack      = grant_vec;
                o_AesStart = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (i_AesDone || tmo_hit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                o_Done     = grant_vec;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign grant_vec = NUM_REQ'(1) << idx_q;

    // Operands are captured only at grant so the core sees them stable until the next capture.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            text_q   <= '0;
            key_q    <= '0;
            dec_q    <= 1'b0;
            idx_q    <= '0;
            c_Last   <= IDX_W'(NUM_REQ - 1);
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        text_q <= sel_text;
                        key_q  <= sel_key;
                        dec_q  <= sel_dec;
                        idx_q  <= pick_idx;
                    end
                end
                WAIT: begin
                    if (i_AesDone) begin
                        result_q <= i_AesData;
                    end else if (tmo_hit) begin
                        result_q <= '0;
                    end
                end
                DONE: begin
                    c_Last <= idx_q;
                end
                default: ;
            endcase
        end
    end

    assign o_Data    = result_q;
    assign o_AesText = text_q;
    assign o_AesKey  = key_q;
    assign o_AesDec  = dec_q;

`ifdef AES_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] tmo_cnt;
    logic                 err_q;

    // A done arriving on the limit cycle takes priority over the timeout.
    assign tmo_hit = (state == WAIT) && (tmo_cnt == TMO_CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == START) begin
                tmo_cnt <= '0;
            end else if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (state == WAIT) begin
                if (i_AesDone) begin
                    err_q <= 1'b0;
                end else if (tmo_hit) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign o_Err = (state == DONE) && err_q;
`else
    // No counter: WAIT lasts until the core answers; the parameter stays referenced.
    assign tmo_hit = 1'b0 && (TIMEOUT_CYC > 0);
    assign o_Err   = 1'b0;
`endif

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed scoreboard bench for aes_req_arbiter; the bench plays the AES core.
// Define AES_TIMEOUT_EN to also exercise the wait timeout.
module tb_aes_req_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int IDX_W       = 2;
    localparam int TIMEOUT_CYC = 8;
    localparam int BLK         = 128;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [BLK-1:0]   data;
        logic             err;
    } exp_t;

    logic                   i_Clk = 1'b0;
    logic                   i_Rst;
    logic [NUM_REQ-1:0]     i_Req;
    logic [NUM_REQ-1:0]     i_Dec;
    logic [NUM_REQ*BLK-1:0] i_Text;
    logic [NUM_REQ*BLK-1:0] i_Key;
    logic [NUM_REQ-1:0]     o_Ack;
    logic [NUM_REQ-1:0]     o_Done;
    logic [BLK-1:0]         o_Data;
    logic                   o_Err;
    logic                   o_Busy;
    logic                   o_AesStart;
    logic                   o_AesDec;
    logic [BLK-1:0]         o_AesText;
    logic [BLK-1:0]         o_AesKey;
    logic [BLK-1:0]         i_AesData;
    logic                   i_AesDone;

    exp_t           exp_q[$];
    exp_t           cur;
    logic [BLK-1:0] text_tb [NUM_REQ];
    logic [BLK-1:0] key_tb  [NUM_REQ];
    logic           dec_tb  [NUM_REQ];
    logic [BLK-1:0] core_result;
    logic [BLK-1:0] last_data;
    int             total = 0;
    int             bad   = 0;

    always #5 i_Clk = ~i_Clk;

    aes_req_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .IDX_W       (IDX_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Req      (i_Req),
        .i_Dec      (i_Dec),
        .i_Text     (i_Text),
        .i_Key      (i_Key),
        .o_Ack      (o_Ack),
        .o_Done     (o_Done),
        .o_Data     (o_Data),
        .o_Err      (o_Err),
        .o_Busy     (o_Busy),
        .o_AesStart (o_AesStart),
        .o_AesDec   (o_AesDec),
        .o_AesText  (o_AesText),
        .o_AesKey   (o_AesKey),
        .i_AesData  (i_AesData),
        .i_AesDone  (i_AesDone)
    );

    // Stand-in core: the FIPS-197 vector, otherwise a cheap keyed, direction-dependent mix.
    function automatic logic [BLK-1:0] fake_aes(input logic [BLK-1:0] t, input logic [BLK-1:0] k,
                                                input logic d);
        if (!d && t == 128'h00112233445566778899aabbccddeeff
               && k == 128'h000102030405060708090a0b0c0d0e0f) begin
            return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        end
        return t ^ {k[63:0], k[127:64]} ^ {BLK{d}};
    endfunction

    task automatic checkOutput(input string tag, input logic [BLK-1:0] observed,
                               input logic [BLK-1:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] req);
        for (int n = 0; n < NUM_REQ; n++) begin
            i_Text[n*BLK +: BLK] = text_tb[n];
            i_Key[n*BLK +: BLK]  = key_tb[n];
            i_Dec[n]             = dec_tb[n];
        end
        i_Req = req;
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic push_exp(input int n);
        exp_t e;
        e.idx  = IDX_W'(n);
        e.data = fake_aes(text_tb[n], key_tb[n], dec_tb[n]);
        e.err  = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic check_zero_outputs(input string pfx);
        checkOutput({pfx, "_ack"},   128'(o_Ack), '0);
        checkOutput({pfx, "_done"},  128'(o_Done), '0);
        checkOutput({pfx, "_data"},  o_Data, '0);
        checkOutput({pfx, "_err"},   128'(o_Err), '0);
        checkOutput({pfx, "_busy"},  128'(o_Busy), '0);
        checkOutput({pfx, "_start"}, 128'(o_AesStart), '0);
        checkOutput({pfx, "_dec"},   128'(o_AesDec), '0);
        checkOutput({pfx, "_text"},  o_AesText, '0);
        checkOutput({pfx, "_key"},   o_AesKey, '0);
    endtask

    task automatic do_reset();
        i_Rst     = 1'b0;
        i_Req     = '0;
        i_AesDone = 1'b0;
        step();
        check_zero_outputs("rst");
        i_Rst = 1'b1;
        step();
        checkOutput("post_rst_busy", 128'(o_Busy), '0);
        last_data = '0;
    endtask

    task automatic wait_start(output int waited);
        waited = 0;
        do begin
            step();
            waited++;
        end while (!o_AesStart && waited < 100);
        checkOutput("start_seen", 128'(o_AesStart), 128'd1);
        if (exp_q.size() == 0) begin
            $display("[TB] FAIL sb_empty: observed=0 entries expected=1");
            $fatal(1, "[TB] scoreboard empty at start");
        end
        cur = exp_q[0];
        checkOutput("ack_vec",  128'(o_Ack), 128'(4'b0001 << cur.idx));
        checkOutput("aes_text", o_AesText, text_tb[cur.idx]);
        checkOutput("aes_key",  o_AesKey, key_tb[cur.idx]);
        checkOutput("aes_dec",  128'(o_AesDec), 128'(dec_tb[cur.idx]));
        checkOutput("busy_start", 128'(o_Busy), 128'd1);
        core_result = fake_aes(o_AesText, o_AesKey, o_AesDec);
    endtask

    task automatic finish_op(input int lat, input bit drop, input bit spur);
        if (drop) i_Req[cur.idx] = 1'b0;
        if (spur) begin
            i_AesDone = 1'b1;
            i_AesData = '1;
        end
        step();
        i_AesDone = 1'b0;
        checkOutput("ack_pulse",   128'(o_Ack), '0);
        checkOutput("start_pulse", 128'(o_AesStart), '0);
        checkOutput("wait_nodone", 128'(o_Done), '0);
        checkOutput("wait_busy",   128'(o_Busy), 128'd1);
        checkOutput("hold_data",   o_Data, last_data);
        for (int i = 1; i < lat; i++) step();
        i_AesDone = 1'b1;
        i_AesData = core_result;
        step();
        i_AesDone = 1'b0;
        i_AesData = '0;
        cur = exp_q.pop_front();
        checkOutput("done_vec",  128'(o_Done), 128'(4'b0001 << cur.idx));
        checkOutput("done_data", o_Data, cur.data);
        checkOutput("done_err",  128'(o_Err), 128'(cur.err));
        last_data = cur.data;
        step();
        checkOutput("idle_busy",  128'(o_Busy), '0);
        checkOutput("done_pulse", 128'(o_Done), '0);
    endtask

    initial begin
        int w;
        text_tb[0] = 128'h00112233445566778899aabbccddeeff;
        key_tb[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        dec_tb[0]  = 1'b0;
        text_tb[1] = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        key_tb[1]  = 128'h11111111_22222222_33333333_44444444;
        dec_tb[1]  = 1'b1;
        text_tb[2] = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        key_tb[2]  = 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;
        dec_tb[2]  = 1'b0;
        text_tb[3] = 128'h13579bdf_2468ace0_fedcba98_76543210;
        key_tb[3]  = 128'h0badc0de_feedface_12345678_9abcdef0;
        dec_tb[3]  = 1'b1;
        i_Rst = 1'b0; i_Req = '0; i_Dec = '0; i_Text = '0; i_Key = '0;
        i_AesDone = 1'b0; i_AesData = '0; last_data = '0;

        do_reset();

        $display("[TB] single request, FIPS-197 vector");
        applyStimulus(4'b0001);
        push_exp(0);
        wait_start(w);
        checkOutput("ack_latency", 128'(w), 128'd1);
        finish_op(3, 1'b1, 1'b0);

        $display("[TB] simultaneous requests from reset");
        do_reset();
        applyStimulus(4'b0011);
        push_exp(0);
        wait_start(w);
        finish_op(2, 1'b1, 1'b0);
        push_exp(1);
        wait_start(w);
        checkOutput("next_grant_latency", 128'(w), 128'd1);
        finish_op(4, 1'b1, 1'b0);

        $display("[TB] spurious done in IDLE and START");
        i_AesDone = 1'b1;
        i_AesData = '1;
        step();
        i_AesDone = 1'b0;
        checkOutput("spur_idle_done", 128'(o_Done), '0);
        checkOutput("spur_idle_busy", 128'(o_Busy), '0);
        checkOutput("spur_idle_data", o_Data, last_data);
        applyStimulus(4'b0100);
        push_exp(2);
        wait_start(w);
        finish_op(2, 1'b1, 1'b1);

        $display("[TB] sustained contention");
        do_reset();
        applyStimulus(4'b1111);
        for (int k = 0; k < 5; k++) begin
            push_exp(k % NUM_REQ);
            wait_start(w);
            if (k > 0) checkOutput("rr_back_to_back", 128'(w), 128'd1);
            if (k == 4) i_Req = '0;
            finish_op(2, 1'b0, 1'b0);
        end

        $display("[TB] reset during WAIT");
        applyStimulus(4'b1000);
        push_exp(3);
        wait_start(w);
        i_Req = '0;
        step();
        checkOutput("pre_abort_busy", 128'(o_Busy), 128'd1);
        i_Rst = 1'b0;
        #1;
        check_zero_outputs("abort");
        void'(exp_q.pop_front());
        last_data = '0;
        step();
        i_Rst = 1'b1;
        step();
        checkOutput("abort_nodone", 128'(o_Done), '0);
        applyStimulus(4'b0010);
        push_exp(1);
        wait_start(w);
        finish_op(3, 1'b1, 1'b0);

`ifdef AES_TIMEOUT_EN
        $display("[TB] wait timeout");
        begin
            exp_t e;
            int   n;
            applyStimulus(4'b0001);
            e.idx  = '0;
            e.data = '0;
            e.err  = 1'b1;
            exp_q.push_back(e);
            wait_start(w);
            i_Req = '0;
            n = 0;
            do begin
                step();
                n++;
            end while (!o_Done && n < 50);
            cur = exp_q.pop_front();
            checkOutput("tmo_latency", 128'(n), 128'd9);
            checkOutput("tmo_done",    128'(o_Done), 128'(4'b0001 << cur.idx));
            checkOutput("tmo_err",     128'(o_Err), 128'(cur.err));
            checkOutput("tmo_data",    o_Data, cur.data);
            step();
            checkOutput("tmo_idle",    128'(o_Busy), '0);
            checkOutput("tmo_err_pulse", 128'(o_Err), '0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
